hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard detector for the ARM pipeline that replaces the fixed EXE/MEM comparator with an internal scoreboard of in-flight destinations. The scoreboard is DEPTH entries deep. The block sits beside the ID stage and drives the IF/ID stall. In mode `fwd_en=1` it stalls only on load-use. In mode `fwd_en=0` it stalls on any RAW against any in-flight writer. It inserts bubbles, honours branch flush and memory freeze, and counts stall cycles.

## Interface
- `REG_AW`, default 4: register address width.
- `DEPTH`, default 2: in-flight stages tracked between ID and WB. Entry 0 is EXE, entry DEPTH-1 is the last stage before WB commit. DEPTH ≥ 1.
- `CNT_W`, default 16: stall-counter width.
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-high.
- `id_valid`, in, 1: the ID stage holds a real instruction.
- `id_rn`, in, REG_AW: first source address.
- `id_rm`, in, REG_AW: second source address.
- `id_two_src`, in, 1: `id_rm` is a live source.
- `id_wb_en`, in, 1: the ID instruction writes a register.
- `id_dest`, in, REG_AW: its destination address.
- `id_mem_read`, in, 1: the ID instruction is a load.
- `fwd_en`, in, 1: forwarding present. Only load-use stalls.
- `flush`, in, 1: taken branch resolved. The ID instruction is killed.
- `mem_freeze`, in, 1: memory busy. The whole pipeline holds.
- `hazard`, out, 1: stall IF/ID this cycle. Combinational.
- `hazard_stage`, out, DEPTH: one-hot/multi-hot mask of the entries that matched. Combinational.
- `stall_cnt`, out, CNT_W: saturating count of stall cycles. Registered.

## Operation
- Each scoreboard entry k holds `{v, wb, mrd, dest}`.
- Reset: all entries have `v=0`, and `stall_cnt=0`. With all entries invalid, `hazard=0` and `hazard_stage=0`.
- Match for entry k, written `m[k]`, is true when all of the following hold:
  - `v[k]` and `wb[k]` are both set;
  - `dest[k]==id_rn`, or `id_two_src` is set and `dest[k]==id_rm`.
- Stall condition for entry k:
  - With `fwd_en=0`: `s[k]=m[k]`.
  - With `fwd_en=1`: `s[k]=m[k] & mrd[k] & (k==0)`. This is the load-use case only; older loads are forwarded.
- Output gating:
  - `hazard_stage[k] = s[k] & id_valid & ~flush`.
  - `hazard = |hazard_stage`.
- Scoreboard update priority, highest first:
  1. `rst`: clear all entries.
  2. `mem_freeze`: hold all entries unchanged.
  3. Shift. Entry k receives entry k-1 for k ≥ 1, and entry DEPTH-1 retires.
- Entry 0 load value when shifting:
  - If `flush`, `hazard`, or `!id_valid`: load a bubble (`v=0`).
  - Otherwise: load `{1, id_wb_en, id_mem_read, id_dest}`.
- A bubble always has `wb=0` and `mrd=0`.
- `stall_cnt`:
  - Increments when `hazard & ~mem_freeze`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `rst`.
- `flush` and `hazard` never assert together, because flush masks hazard. Flush does not clear older entries; those instructions are ahead of the branch and commit.
- Address compare is full-width equality. No address is special-cased.

## Timing
- `hazard` and `hazard_stage` are combinational from the inputs and the current entries, valid in the same cycle. There is no register between ID inputs and `hazard`.
- Stall duration with `fwd_en=0`:
  - A dependency on entry k stalls until the writer retires.
  - That is DEPTH−k stall cycles, with no freeze.
- Stall duration with `fwd_en=1`: load-use stalls exactly 1 cycle. The load moves to entry 1 and the bubble takes entry 0.
- `mem_freeze` stretches any stall by its asserted duration. The match re-evaluates every cycle against the held entries.
- Counter behaviour:
  - `stall_cnt` reflects the cycle's hazard one edge later.
  - It does not count frozen cycles.
- Reset mid-stall:
  - `hazard` drops in the cycle after the `rst` edge.
  - `stall_cnt` reads 0 after that edge.

## Test plan
- Reset, then ID with `id_rn=3` and no prior writers → `hazard=0`, `stall_cnt=0`.
- `fwd_en=0`, DEPTH=2:
  - Issue `{wb=1, dest=5}`, then an ID instruction with `id_rn=5`.
  - Required: `hazard=1` for 2 cycles with `hazard_stage` = 01 then 10, then 0.
  - Required: `stall_cnt=2`.
- `fwd_en=1`:
  - Issue a load `{wb=1, mrd=1, dest=7}`, then ID with `id_two_src=1, id_rm=7`.
  - Required: exactly 1 stall cycle.
  - Repeat with a non-load writer: 0 stall cycles.
- Same setup as the first stall case, but with `flush=1` in the stall cycle:
  - Required: `hazard=0`.
  - Required: entry 0 loads a bubble, and the older entry still shifts to entry 1.
- Load-use with `fwd_en=1` and `mem_freeze=1` for 3 cycles:
  - Required: `hazard` held 1 across the freeze, and the scoreboard is unchanged.
  - Required: `stall_cnt` advances by 1 only, on the unfrozen cycle.
- `CNT_W=2`: force 5 stall cycles → `stall_cnt` saturates at 3. Assert `rst` → 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard of in-flight destinations that stalls ID on RAW hazards,
// inserts bubbles, honours flush/freeze and counts stall cycles.
module hazard_scoreboard #(
  parameter int REG_AW = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_mem_read,
  input  logic              fwd_en,
  input  logic              flush,
  input  logic              mem_freeze,
  output logic              hazard,
  output logic [DEPTH-1:0]  hazard_stage,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [DEPTH-1:0]  v, wb, mrd;
  logic [REG_AW-1:0] dest [DEPTH];
  logic              load;
  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    logic m;
    assign m = v[k] & wb[k] & ((dest[k] == id_rn) | (id_two_src & (dest[k] == id_rm)));
    // with forwarding only a load sitting in EXE cannot be bypassed
    assign hazard_stage[k] = (fwd_en ? (m & mrd[k] & (k == 0)) : m) & id_valid & ~flush;
  end
  assign hazard = |hazard_stage;
  assign load   = id_valid & ~flush & ~hazard;
  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= '0;
      wb        <= '0;
      mrd       <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) dest[k] <= '0;
    end else begin
      if (!mem_freeze) begin
        v[0]    <= load;
        wb[0]   <= load & id_wb_en;
        mrd[0]  <= load & id_mem_read;
        dest[0] <= id_dest;
        for (int k = 1; k < DEPTH; k++) begin
          v[k]    <= v[k-1];
          wb[k]   <= wb[k-1];
          mrd[k]  <= mrd[k-1];
          dest[k] <= dest[k-1];
        end
      end
      if (hazard & ~mem_freeze & ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of stall, flush, freeze, saturation and reset behaviour.
module tb_hazard_scoreboard;
  logic       clk = 0;
  logic       rst, id_valid, id_two_src, id_wb_en, id_mem_read, fwd_en, flush, mem_freeze;
  logic [3:0] id_rn, id_rm, id_dest;
  logic       hazard, s_hazard;
  logic [1:0] hazard_stage, s_stage;
  logic [15:0] stall_cnt;
  logic [1:0]  s_cnt;
  int passed = 0, failed = 0, total = 0;
  logic [6:0] pat;

  hazard_scoreboard #(.REG_AW(4), .DEPTH(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
    .fwd_en(fwd_en), .flush(flush), .mem_freeze(mem_freeze),
    .hazard(hazard), .hazard_stage(hazard_stage), .stall_cnt(stall_cnt));

  hazard_scoreboard #(.REG_AW(4), .DEPTH(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
    .fwd_en(fwd_en), .flush(flush), .mem_freeze(mem_freeze),
    .hazard(s_hazard), .hazard_stage(s_stage), .stall_cnt(s_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rn = 0; id_rm = 0; id_two_src = 0; id_wb_en = 0;
    id_dest = 0; id_mem_read = 0; flush = 0; mem_freeze = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [3:0] d, input logic ld);
    id_valid = 1; id_rn = 4'hf; id_rm = 4'hf; id_two_src = 0;
    id_wb_en = 1; id_dest = d; id_mem_read = ld;
    tick();
  endtask

  initial begin
    fwd_en = 0;
    do_reset();
    tick();
    // no prior writers
    id_valid = 1; id_rn = 3;
    #1;
    check("reset_hazard", hazard, 0);
    check("reset_stage", hazard_stage, 0);
    check("reset_cnt", stall_cnt, 0);

    // fwd_en=0 RAW on dest 5 stalls DEPTH cycles
    do_reset();
    issue(5, 0);
    id_rn = 5; id_wb_en = 0; id_dest = 9;
    #1;
    check("raw_h0", hazard, 1);
    check("raw_st0", hazard_stage, 2'b01);
    tick();
    check("raw_h1", hazard, 1);
    check("raw_st1", hazard_stage, 2'b10);
    check("raw_cnt1", stall_cnt, 1);
    tick();
    check("raw_h2", hazard, 0);
    check("raw_st2", hazard_stage, 0);
    check("raw_cnt2", stall_cnt, 2);

    // fwd_en=1 load-use via second source
    do_reset();
    fwd_en = 1;
    issue(7, 1);
    id_rn = 2; id_rm = 7; id_two_src = 0; id_wb_en = 0; id_mem_read = 0;
    #1;
    check("lu_rm_dead", hazard, 0);
    id_two_src = 1;
    #1;
    check("lu_h0", hazard, 1);
    check("lu_st0", hazard_stage, 2'b01);
    tick();
    check("lu_h1", hazard, 0);
    check("lu_cnt", stall_cnt, 1);

    // non-load writer: forwarded, no stall unless forwarding is off
    do_reset();
    issue(7, 0);
    id_rn = 2; id_rm = 7; id_two_src = 1; id_wb_en = 0;
    #1;
    check("nl_h", hazard, 0);
    fwd_en = 0;
    #1;
    check("nl_nofwd_h", hazard, 1);
    fwd_en = 1;
    tick();
    check("nl_cnt", stall_cnt, 0);

    // flush in stall cycle: ID killed, writer still shifts to entry 1
    do_reset();
    fwd_en = 0;
    issue(5, 0);
    id_rn = 5; id_wb_en = 1; id_dest = 5; flush = 1;
    #1;
    check("fl_h", hazard, 0);
    check("fl_st", hazard_stage, 0);
    tick();
    flush = 0;
    #1;
    check("fl_cnt", stall_cnt, 0);
    check("fl_next_st", hazard_stage, 2'b10);

    // load-use held across a 3-cycle freeze
    do_reset();
    fwd_en = 1;
    issue(7, 1);
    id_rn = 7; id_wb_en = 0; id_mem_read = 0; mem_freeze = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("fz_h%0d", i), hazard, 1);
      check($sformatf("fz_st%0d", i), hazard_stage, 2'b01);
      tick();
      check($sformatf("fz_cnt%0d", i), stall_cnt, 0);
    end
    mem_freeze = 0;
    #1;
    check("fz_h_rel", hazard, 1);
    tick();
    check("fz_h_after", hazard, 0);
    check("fz_cnt_after", stall_cnt, 1);

    // 5 stall cycles: 2-bit counter saturates at 3
    do_reset();
    fwd_en = 0;
    id_valid = 1; id_rn = 5; id_wb_en = 1; id_dest = 5;
    tick();
    pat = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("sat_h%0d", i), hazard, {31'd0, pat[i]});
      tick();
    end
    check("sat_cnt2", s_cnt, 3);
    check("sat_cnt16", stall_cnt, 5);

    // reset in the middle of a stall
    check("mid_h_before", hazard, 1);
    rst = 1;
    tick();
    rst = 0;
    check("mid_h_after", hazard, 0);
    check("mid_cnt16", stall_cnt, 0);
    check("mid_cnt2", s_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
